// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-slave-select SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE,
        BURST
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

    // Width of an index into n items, never below one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: H-cycle half-period counter, SCLK level and edge strobes.
module spi_sclk_gen #(
    parameter int SCLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle_en,
    input  logic load,
    input  logic cpol,
    output logic sclk,
    output logic half_tick,
    output logic lead_edge,
    output logic trail_edge
);

    localparam int H     = SCLK_DIV / 2;
    localparam int CNT_W = $clog2(H);

    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        half_tick  = en && (cnt_q == CNT_W'(H - 1));
        // Leading edge moves SCLK away from its idle level, trailing edge returns it.
        lead_edge  = half_tick && toggle_en && (sclk == cpol);
        trail_edge = half_tick && toggle_en && (sclk != cpol);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else begin
            if (!en || half_tick)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;

            if (load)
                sclk <= cpol;
            else if (half_tick && toggle_en)
                sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_mstr_ss.sv
// SPI master with NUM_SS decoded active-low selects and per-word CPOL/CPHA.
// Optional SPI_BURST_EN adds keep_ss to hold the select across consecutive words.
module spi_mstr_ss
    import spi_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_SS   = 5,
    parameter int SCLK_DIV = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wrt,
    input  logic [DATA_W-1:0]               cmd,
    input  logic [clog2_min1(NUM_SS)-1:0]   ss_sel,
    input  logic [1:0]                      mode,
`ifdef SPI_BURST_EN
    input  logic                            keep_ss,
`endif
    input  logic                            MISO,
    output logic                            SCLK,
    output logic                            MOSI,
    output logic [NUM_SS-1:0]               SS_n,
    output logic                            busy,
    output logic                            done,
    output logic [DATA_W-1:0]               data
);

    localparam int SS_W = clog2_min1(NUM_SS);
    localparam int HC_W = $clog2(2 * DATA_W);
    localparam logic [HC_W-1:0] LAST_HALF = HC_W'(2 * DATA_W - 1);

    spi_state_t        state_q, state_nxt;
    spi_mode_t         mode_q, mode_nxt;
    logic [SS_W-1:0]   sel_q, sel_nxt;
    logic              keep_q;
    logic [HC_W-1:0]   hcnt_q;
    logic [DATA_W-1:0] tx_q, rx_q;
    logic              accept, from_burst, en, toggle_en, last_half;
    logic              half_tick, lead_edge, trail_edge, sample, update;

    function automatic logic [NUM_SS-1:0] ss_decode(input logic act, input logic [SS_W-1:0] sel);
        ss_decode = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (act && (sel == SS_W'(i)))
                ss_decode[i] = 1'b0;
    endfunction

    always_comb begin
        accept     = wrt && (state_q inside {IDLE, DONE, BURST});
        from_burst = (state_q == BURST);
        // A word continuing a burst keeps the slave and mode of the first word.
        mode_nxt   = (accept && !from_burst) ? spi_mode_t'(mode) : mode_q;
        sel_nxt    = (accept && !from_burst) ? ss_sel : sel_q;
        en         = state_q inside {SETUP, SHIFT, HOLD};
        toggle_en  = (state_q == SHIFT);
        last_half  = (hcnt_q == LAST_HALF);
        busy       = en;
        sample     = mode_q.cpha ? trail_edge : lead_edge;
        update     = mode_q.cpha ? lead_edge : (trail_edge && !last_half);
    end

    spi_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .toggle_en  (toggle_en),
        .load       (accept),
        .cpol       (mode_nxt.cpol),
        .sclk       (SCLK),
        .half_tick  (half_tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

`ifdef SPI_BURST_EN
    always_ff @(posedge clk) begin
        if (rst)
            keep_q <= 1'b0;
        else if (accept)
            keep_q <= keep_ss;
    end
`else
    assign keep_q = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (half_tick) state_nxt = SHIFT;
            SHIFT:   if (half_tick && last_half) state_nxt = HOLD;
            HOLD:    if (half_tick) state_nxt = keep_q ? BURST : DONE;
            DONE:    state_nxt = accept ? SETUP : IDLE;
            BURST:   if (accept) state_nxt = SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE0;
            SS_n    <= '1;
            done    <= 1'b0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_nxt;
            mode_q  <= mode_nxt;
            SS_n    <= ss_decode(state_nxt inside {SETUP, SHIFT, HOLD, BURST}, sel_nxt);
            if (accept)
                done <= 1'b0;
            else if (state_q == HOLD && half_tick)
                done <= 1'b1;
            if (state_q != SHIFT)
                hcnt_q <= '0;
            else if (half_tick)
                hcnt_q <= hcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            MOSI <= 1'b0;
            data <= '0;
        end else begin
            // CPHA=0 presents the MSB before the first leading edge.
            if (accept && !mode_nxt.cpha)
                MOSI <= cmd[DATA_W-1];
            else if (update)
                MOSI <= tx_q[DATA_W-1];
            if (state_q == HOLD && half_tick)
                data <= rx_q;
        end
    end

    always_ff @(posedge clk) begin
        sel_q <= sel_nxt;
        if (accept)
            tx_q <= mode_nxt.cpha ? cmd : {cmd[DATA_W-2:0], 1'b0};
        else if (update)
            tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        if (sample)
            rx_q <= {rx_q[DATA_W-2:0], MISO};
    end

endmodule
